// File: rtl/cordic_pkg.sv
// Shared constants for the rotation-mode CORDIC datapath: iteration count,
// counter width, the arctangent table and the CORDIC gain correction, all
// held in Q2.30, plus the helper that rescales them to the datapath width.
package cordic_pkg;

    localparam int CORDIC_ITERS = 16;
    localparam int ITR_W        = 4;

    // atan(2^-i) in Q2.30 for i = 0..15
    localparam logic [31:0] ATAN_Q30 [0:15] = '{
        32'd843314857,
        32'd497837829,
        32'd263043837,
        32'd133525159,
        32'd67021687,
        32'd33543516,
        32'd16775851,
        32'd8388437,
        32'd4194283,
        32'd2097149,
        32'd1048576,
        32'd524288,
        32'd262144,
        32'd131072,
        32'd65536,
        32'd32768
    };

    // 1/gain of 16 CORDIC stages, 0.607252935, in Q2.30
    localparam logic [31:0] K_Q30 = 32'd652032874;

    // Rescale a non-negative Q2.30 constant to Q2.(w-2), rounding to nearest
    // (halves round up). w is limited to 12..30, so the shift is 2..20.
    function automatic logic [31:0] q30_to_q(input logic [31:0] v, input int w);
        int          sh;
        logic [32:0] acc;
        sh  = 32 - w;
        acc = {1'b0, v} + (33'd1 << (sh - 1));
        acc = acc >> sh;
        return acc[31:0];
    endfunction

endpackage

// File: rtl/cordic_dpath_atan_rom.sv
// Combinational arctangent table: returns atan(2^-i) in Q2.(W-2) for the
// current iteration index, derived from the Q2.30 master table.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [ITR_W-1:0]    i_idx,
    output logic signed [W-1:0] o_atan
);

    logic [31:0] w_scaled;

    // Look up the Q2.30 entry and round it down to the datapath width
    always_comb begin
        w_scaled = 32'd0;
        w_scaled = q30_to_q(ATAN_Q30[i_idx], W);
    end

    assign o_atan = w_scaled[W-1:0];

endmodule

// File: rtl/cordic_dpath.sv
// Rotation-mode CORDIC datapath. The controller strobes ld/init to start a
// job, ld alone to advance one micro-rotation, and fin to capture cos/sin.
// The iteration index is fed back so the controller can end after 16 steps.
module cordic_dpath
    import cordic_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld,
    input  logic                init,
    input  logic                fin,
    input  logic signed [W-1:0] theta,
    output logic [ITR_W-1:0]    itr,
    output logic signed [W-1:0] cos_q,
    output logic signed [W-1:0] sin_q,
    output logic                res_vld
);

    // Starting x value pre-compensates the CORDIC gain so no final scaling is needed
    localparam logic [31:0]        K_FULL = q30_to_q(K_Q30, W);
    localparam logic signed [W-1:0] K_INIT = K_FULL[W-1:0];

    logic signed [W-1:0] r_x;
    logic signed [W-1:0] r_y;
    logic signed [W-1:0] r_z;
    logic [ITR_W-1:0]    r_itr;
    logic signed [W-1:0] r_cos;
    logic signed [W-1:0] r_sin;
    logic                r_vld;

    logic signed [W-1:0] w_atan;
    logic signed [W-1:0] w_x_sh;
    logic signed [W-1:0] w_y_sh;
    logic signed [W-1:0] w_x_nxt;
    logic signed [W-1:0] w_y_nxt;
    logic signed [W-1:0] w_z_nxt;
    logic [ITR_W-1:0]    w_itr_nxt;
    logic                w_load;
    logic                w_step;

    cordic_atan_rom #(
        .W (W)
    ) u_atan_rom (
        .i_idx  (r_itr),
        .o_atan (w_atan)
    );

    assign w_load = ld & init;
    assign w_step = ld & ~init;

    // One micro-rotation: rotate toward z = 0 by +/- atan(2^-i); sums wrap, no saturation
    always_comb begin
        w_x_sh    = r_x >>> r_itr;
        w_y_sh    = r_y >>> r_itr;
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        w_z_nxt   = r_z;
        w_itr_nxt = r_itr + 4'd1;
        if (r_z[W-1]) begin
            // residual angle negative: d = -1
            w_x_nxt = r_x + w_y_sh;
            w_y_nxt = r_y - w_x_sh;
            w_z_nxt = r_z + w_atan;
        end else begin
            // residual angle non-negative: d = +1
            w_x_nxt = r_x - w_y_sh;
            w_y_nxt = r_y + w_x_sh;
            w_z_nxt = r_z - w_atan;
        end
    end

    // Working registers: reset, load a new job, iterate, or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_itr <= '0;
        end else if (w_load) begin
            r_x   <= K_INIT;
            r_y   <= '0;
            r_z   <= theta;
            r_itr <= '0;
        end else if (w_step) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_z   <= w_z_nxt;
            r_itr <= w_itr_nxt;
        end else begin
            r_x   <= r_x;
            r_y   <= r_y;
            r_z   <= r_z;
            r_itr <= r_itr;
        end
    end

    // Result registers: invalidated by a load, captured on fin, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cos <= '0;
            r_sin <= '0;
            r_vld <= 1'b0;
        end else if (w_load) begin
            r_cos <= r_cos;
            r_sin <= r_sin;
            r_vld <= 1'b0;
        end else if (fin) begin
            r_cos <= r_x;
            r_sin <= r_y;
            r_vld <= 1'b1;
        end else begin
            r_cos <= r_cos;
            r_sin <= r_sin;
            r_vld <= r_vld;
        end
    end

    assign itr     = r_itr;
    assign cos_q   = r_cos;
    assign sin_q   = r_sin;
    assign res_vld = r_vld;

endmodule

// File: tb/tb_cordic_dpath.sv
// Self-checking bench for cordic_dpath (W=16). The controller's ld/init/fin
// sequence is generated by tasks here; results are compared with real-valued
// cos/sin scaled to Q2.14, within +/-8 LSB.
module tb_cordic_dpath;

    localparam int W   = 16;
    localparam int TOL = 8;

    logic                clk;
    logic                rst;
    logic                ld;
    logic                init;
    logic                fin;
    logic signed [W-1:0] theta;
    logic [3:0]          itr;
    logic signed [W-1:0] cos_q;
    logic signed [W-1:0] sin_q;
    logic                res_vld;

    int n_tests;
    int n_fail;
    int exp_vld;

    cordic_dpath #(
        .W (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .init    (init),
        .fin     (fin),
        .theta   (theta),
        .itr     (itr),
        .cos_q   (cos_q),
        .sin_q   (sin_q),
        .res_vld (res_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int diff;
        n_tests++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_cos(input int th);
        return int'($floor($cos(real'(th) / 16384.0) * 16384.0 + 0.5));
    endfunction

    function automatic int ref_sin(input int th);
        return int'($floor($sin(real'(th) / 16384.0) * 16384.0 + 0.5));
    endfunction

    // Full controller-style job: load, 16 iterations (optional 3-cycle hold), finish
    task automatic run_job(input int th, input int hold_at, input int ec, input int es);
        if (exp_vld == 1) chk("vld_before_load", int'(res_vld), 1, 0);
        theta = W'(th);
        ld    = 1'b1;
        init  = 1'b1;
        fin   = 1'b0;
        step();
        init  = 1'b0;
        exp_vld = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == hold_at) begin
                ld   = 1'b0;
                init = 1'b1;
                for (int h = 0; h < 3; h++) begin
                    step();
                    chk("hold_itr", int'(itr), k, 0);
                end
                ld   = 1'b1;
                init = 1'b0;
            end
            chk("exec_itr", int'(itr), k, 0);
            chk("exec_vld", int'(res_vld), 0, 0);
            step();
        end
        ld  = 1'b0;
        fin = 1'b1;
        chk("finish_itr", int'(itr), 0, 0);
        step();
        fin = 1'b0;
        chk("res_vld", int'(res_vld), 1, 0);
        chk("cos_q", int'(cos_q), ec, TOL);
        chk("sin_q", int'(sin_q), es, TOL);
        exp_vld = 1;
    endtask

    initial begin
        int th;
        n_tests = 0;
        n_fail  = 0;
        exp_vld = 0;
        rst   = 1'b1;
        ld    = 1'b0;
        init  = 1'b0;
        fin   = 1'b0;
        theta = '0;

        // Reset
        step();
        step();
        chk("rst_itr", int'(itr), 0, 0);
        chk("rst_cos", int'(cos_q), 0, 0);
        chk("rst_sin", int'(sin_q), 0, 0);
        chk("rst_vld", int'(res_vld), 0, 0);
        rst = 1'b0;
        step();

        // Directed angles, back to back (each load follows the previous FINISH)
        run_job(0,      -1, 16384, 0);
        run_job(8579,   -1, 14189, 8192);
        run_job(-12868, -1, 11585, -11585);
        run_job(25736,  -1, 0,     16384);
        run_job(-25736, -1, 0,     -16384);

        // Hold mid-job with init forced but ld low
        run_job(5000, 5, ref_cos(5000), ref_sin(5000));

        // Abort with rst at itr == 7
        step();
        theta = W'(-7000);
        ld    = 1'b1;
        init  = 1'b1;
        step();
        init  = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("abort_itr_pre", int'(itr), 7, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ld  = 1'b0;
        exp_vld = 0;
        chk("abort_itr", int'(itr), 0, 0);
        chk("abort_cos", int'(cos_q), 0, 0);
        chk("abort_sin", int'(sin_q), 0, 0);
        chk("abort_vld", int'(res_vld), 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_vld_hold", int'(res_vld), 0, 0);
        end
        run_job(-7000, -1, ref_cos(-7000), ref_sin(-7000));

        // Random angles within +/- pi/2
        for (int n = 0; n < 12; n++) begin
            th = int'($urandom_range(51472)) - 25736;
            run_job(th, -1, ref_cos(th), ref_sin(th));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
